uart_str_reader: RTL and testbench
==================================

Name: uart_str_reader

Overview:
- Reads a null-terminated byte string from a synchronous read-only memory (1-cycle read latency) and feeds it byte by byte to a UART transmitter using a start/busy handshake.
- Sits between the string ROM and the UART TX.
- One start_i pulse sends one complete string.

Parameters:
ADDR_W, 4, memory address width; maximum string length is 2**ADDR_W bytes.
DATA_W, 8, memory and UART data width.
START_ADDR, 0, address of the first character.
ACK_WAIT, 4, clocks to wait for tx_busy_i to rise after tx_start_o; range 1..15.

Ports:
clk_i  input  1  system clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
start_i  input  1  request to send the string; sampled only in IDLE.
addr_o  output  ADDR_W  memory read address (registered).
data_i  input  DATA_W  memory read data; valid one clock after addr_o changes.
tx_data_o  output  DATA_W  byte to transmit; held stable from tx_start_o until the next byte is latched.
tx_start_o  output  1  one-clock pulse requesting transmission of tx_data_o.
tx_busy_i  input  1  UART transmitter busy flag.
busy_o  output  1  high whenever state is not IDLE.
done_o  output  1  one-clock pulse when the string ends.
count_o  output  ADDR_W+1  bytes sent in the last or current string.

Behaviour:
- Reset values (asynchronous, rst_ni low): state IDLE, addr_o=START_ADDR, tx_data_o=0, tx_start_o=0, busy_o=0, done_o=0, count_o=0, ack counter=0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: addr_o=START_ADDR. If start_i=1: count_o<=0, go to FETCH.
  - FETCH: one clock for the memory read; go to CHECK.
  - CHECK: data_i is valid.
    - data_i==0: go to FIN.
    - Otherwise: tx_data_o<=data_i, go to WAIT_RDY.
  - WAIT_RDY: stay while tx_busy_i=1. When tx_busy_i=0: assert tx_start_o for exactly one clock, clear the ack counter, go to WAIT_ACK.
  - WAIT_ACK: count clocks.
    - tx_busy_i=1: go to WAIT_DONE.
    - Counter reaches ACK_WAIT without seeing busy: treat the byte as sent, go to NEXT.
  - WAIT_DONE: stay while tx_busy_i=1; when it is 0, go to NEXT.
  - NEXT: count_o<=count_o+1.
    - addr_o == 2**ADDR_W-1 (last location, no terminator found): go to FIN; addr_o never wraps.
    - Otherwise: addr_o<=addr_o+1, go to FETCH.
  - FIN: done_o=1 for one clock, go to IDLE. count_o holds its value until the next start.
- Latency: with tx_busy_i low, tx_start_o rises 3 clocks after the edge that samples start_i (IDLE→FETCH→CHECK→WAIT_RDY, pulse registered on the exit edge).
- Minimum per-byte overhead beyond the UART busy time: NEXT+FETCH+CHECK+WAIT_RDY = 4 clocks.
- start_i while busy_o=1: ignored; no queuing.
- start_i held high: a new string starts on the clock after FIN returns to IDLE, and its first byte is fetched again from START_ADDR.
- Empty string (mem[START_ADDR]==0): no tx_start_o pulse; done_o 3 clocks after start; count_o=0.
- Reset mid-string: immediate abort. tx_start_o drops asynchronously, no done_o pulse, state returns to IDLE with reset values.
- tx_start_o is never asserted while tx_busy_i=1 was sampled on the same edge.
- count_o saturation cannot occur: maximum value is 2**ADDR_W, which fits in ADDR_W+1 bits.

Test Plan:
- Memory "Hi\0" at address 0, UART model busy for 10 clocks after each start.
  -> exactly two tx_start_o pulses, with tx_data_o=0x48 then 0x69;
  -> done_o pulse once; count_o=2; addr_o back to 0; busy_o low afterwards.
- mem[0]=0, start pulse.
  -> no tx_start_o; done_o 3 clocks after the start edge; count_o=0.
- All 16 locations non-zero (0x41..0x50).
  -> 16 pulses in address order;
  -> done_o after the byte at address 15; count_o=16; addr_o never observed at 0 mid-string.
- tx_busy_i forced high 20 clocks before the first byte.
  -> tx_start_o withheld until the clock after busy falls;
  -> start_i pulses during transmission produce no extra strings.
- UART model never raises busy (instant TX).
  -> each byte accepted after ACK_WAIT=4 clocks; string "AB\0" completes with count_o=2.
- rst_ni pulled low while the second byte is in WAIT_DONE.
  -> all outputs return to reset values immediately; no done_o;
  -> a new start resends from START_ADDR.

Source files
------------

// File: rtl/uart_str_reader.sv
// Streams a null-terminated string from a 1-cycle-latency ROM into a UART TX
// using a start/busy handshake. One start_i pulse sends one complete string.
module uart_str_reader #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int START_ADDR = 0,
   parameter int ACK_WAIT   = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic [ADDR_W-1:0] addr_o,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] tx_data_o,
   output logic              tx_start_o,
   input  logic              tx_busy_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   count_o
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] CHECK     = 3'd2;
   localparam logic [2:0] WAIT_RDY  = 3'd3;
   localparam logic [2:0] WAIT_ACK  = 3'd4;
   localparam logic [2:0] WAIT_DONE = 3'd5;
   localparam logic [2:0] NEXT      = 3'd6;
   localparam logic [2:0] FIN       = 3'd7;

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
   localparam logic [3:0]        ACK_LAST   = 4'(ACK_WAIT - 1);

   logic [2:0] state_reg;
   logic [3:0] ack_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= IDLE;
         ack_cnt_reg <= '0;
         addr_o      <= FIRST_ADDR;
         tx_data_o   <= '0;
         tx_start_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         count_o     <= '0;
      end else begin
         tx_start_o <= 1'b0;
         done_o     <= 1'b0;
         case (state_reg)
            IDLE: begin
               addr_o <= FIRST_ADDR;
               if (start_i) begin
                  count_o   <= '0;
                  busy_o    <= 1'b1;
                  state_reg <= FETCH;
               end
            end
            FETCH: state_reg <= CHECK;
            CHECK: begin
               if (data_i == '0) begin
                  state_reg <= FIN;
               end else begin
                  tx_data_o <= data_i;
                  state_reg <= WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (!tx_busy_i) begin
                  tx_start_o  <= 1'b1;
                  ack_cnt_reg <= '0;
                  state_reg   <= WAIT_ACK;
               end
            end
            // A UART that never raises busy is treated as having taken the byte.
            WAIT_ACK: begin
               if (tx_busy_i) begin
                  state_reg <= WAIT_DONE;
               end else if (ack_cnt_reg == ACK_LAST) begin
                  state_reg <= NEXT;
               end else begin
                  ack_cnt_reg <= ack_cnt_reg + 4'd1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy_i) state_reg <= NEXT;
            end
            NEXT: begin
               count_o <= count_o + (ADDR_W+1)'(1);
               if (addr_o == LAST_ADDR) begin
                  state_reg <= FIN;
               end else begin
                  addr_o    <= addr_o + ADDR_W'(1);
                  state_reg <= FETCH;
               end
            end
            // Rewind here so a held start_i re-fetches from the first address.
            FIN: begin
               done_o    <= 1'b1;
               busy_o    <= 1'b0;
               addr_o    <= FIRST_ADDR;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_str_reader.sv
// Scoreboard bench for uart_str_reader: ROM and UART models, expected bytes
// queued at stimulus time and popped on each tx_start_o pulse.
module tb_uart_str_reader;

   localparam int BUSY_LEN = 10;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [3:0] addr_o;
   logic [7:0] data_i;
   logic [7:0] tx_data_o;
   logic       tx_start_o;
   logic       tx_busy_i;
   logic       busy_o;
   logic       done_o;
   logic [4:0] count_o;

   uart_str_reader #(
      .ADDR_W(4), .DATA_W(8), .START_ADDR(0), .ACK_WAIT(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .addr_o(addr_o),
      .data_i(data_i), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
      .tx_busy_i(tx_busy_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ROM model, 1-cycle read latency
   logic [7:0] mem [16];
   always @(posedge clk) data_i <= mem[addr_o];

   // UART model
   int   busy_cnt = 0;
   logic force_busy = 1'b0;
   logic uart_instant = 1'b0;
   assign tx_busy_i = force_busy | (busy_cnt != 0);
   always @(negedge clk) begin
      if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
      if (tx_start_o && !uart_instant) busy_cnt = BUSY_LEN;
   end

   // Monitor / scoreboard
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         start_cycs[$];
   int         pulses = 0;
   int         dones = 0;
   int         wrap_err = 0;
   logic       seen_nonzero = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      logic [7:0] e;
      if (tx_start_o) begin
         pulses++;
         start_cycs.push_back(cyc);
         if (exp_q.size() == 0) begin
            check_val("extra_start", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("tx_data", {24'd0, tx_data_o}, {24'd0, e});
            $display("tx byte %02h (expected %02h) at cycle %0d", tx_data_o, e, cyc);
         end
      end
      if (done_o) dones++;
      if (!busy_o) seen_nonzero = 1'b0;
      else if (addr_o != 4'd0) seen_nonzero = 1'b1;
      else if (seen_nonzero) wrap_err++;
   end

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   endtask

   task automatic pulse_start();
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done_o && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check_val(tag, 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int base;
      int d0;
      rst_ni  = 1'b0;
      start_i = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      check_val("rst_addr", {28'd0, addr_o}, 0);
      check_val("rst_tx_data", {24'd0, tx_data_o}, 0);
      check_val("rst_tx_start", {31'd0, tx_start_o}, 0);
      check_val("rst_busy", {31'd0, busy_o}, 0);
      check_val("rst_done", {31'd0, done_o}, 0);
      check_val("rst_count", {27'd0, count_o}, 0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);

      // "Hi"
      mem[0] = 8'h48; mem[1] = 8'h69;
      exp_q.push_back(8'h48); exp_q.push_back(8'h69);
      base = pulses; d0 = dones;
      pulse_start();
      wait_done("hi_timeout");
      check_val("hi_pulses", pulses - base, 2);
      check_val("hi_dones", dones - d0, 1);
      check_val("hi_count", {27'd0, count_o}, 2);
      check_val("hi_addr", {28'd0, addr_o}, 0);
      check_val("hi_busy", {31'd0, busy_o}, 0);
      check_val("hi_queue", exp_q.size(), 0);
      $display("string Hi: count=%0d", count_o);
      repeat (12) @(negedge clk);

      // Empty string: done 3 clocks after the start edge
      clear_mem();
      base = pulses;
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      check_val("empty_done_early", {31'd0, done_o}, 0);
      @(negedge clk);
      check_val("empty_done_at3", {31'd0, done_o}, 1);
      @(negedge clk);
      check_val("empty_pulses", pulses - base, 0);
      check_val("empty_count", {27'd0, count_o}, 0);
      $display("empty string: count=%0d", count_o);

      // 16 non-zero bytes, no terminator
      for (int i = 0; i < 16; i++) begin
         mem[i] = 8'h41 + 8'(i);
         exp_q.push_back(8'h41 + 8'(i));
      end
      base = pulses; d0 = dones;
      pulse_start();
      wait_done("full_timeout");
      check_val("full_pulses", pulses - base, 16);
      check_val("full_dones", dones - d0, 1);
      check_val("full_count", {27'd0, count_o}, 16);
      check_val("full_wrap", wrap_err, 0);
      check_val("full_queue", exp_q.size(), 0);
      $display("string full: count=%0d", count_o);
      repeat (12) @(negedge clk);

      // Busy held high before the first byte; extra starts ignored
      clear_mem();
      mem[0] = 8'h48; mem[1] = 8'h69;
      exp_q.push_back(8'h48); exp_q.push_back(8'h69);
      base = pulses; d0 = dones;
      @(negedge clk) force_busy = 1'b1;
      pulse_start();
      repeat (20) @(negedge clk);
      check_val("held_no_start", pulses - base, 0);
      force_busy = 1'b0;
      @(negedge clk);
      check_val("held_start_after", {31'd0, tx_start_o}, 1);
      repeat (3) @(negedge clk);
      pulse_start();
      repeat (4) @(negedge clk);
      pulse_start();
      wait_done("held_timeout");
      repeat (40) @(negedge clk);
      check_val("held_pulses", pulses - base, 2);
      check_val("held_dones", dones - d0, 1);
      check_val("held_busy", {31'd0, busy_o}, 0);
      $display("busy-held string: count=%0d", count_o);

      // Instant UART: ACK_WAIT timeout accepts each byte
      uart_instant = 1'b1;
      clear_mem();
      mem[0] = 8'h41; mem[1] = 8'h42;
      exp_q.push_back(8'h41); exp_q.push_back(8'h42);
      base = start_cycs.size();
      pulse_start();
      wait_done("inst_timeout");
      if (start_cycs.size() >= base + 2)
         check_val("inst_gap", start_cycs[base+1] - start_cycs[base], 8);
      else
         check_val("inst_pulses", start_cycs.size() - base, 2);
      check_val("inst_count", {27'd0, count_o}, 2);
      $display("instant string: count=%0d", count_o);
      uart_instant = 1'b0;
      repeat (4) @(negedge clk);

      // Reset during WAIT_DONE of the second byte
      clear_mem();
      mem[0] = 8'h48; mem[1] = 8'h69;
      exp_q.push_back(8'h48); exp_q.push_back(8'h69);
      base = pulses; d0 = dones;
      pulse_start();
      begin
         int n;
         n = 0;
         while (pulses < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (n >= 500) check_val("rst_mid_timeout", 0, 1);
      end
      repeat (3) @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check_val("mid_tx_start", {31'd0, tx_start_o}, 0);
      check_val("mid_busy", {31'd0, busy_o}, 0);
      check_val("mid_addr", {28'd0, addr_o}, 0);
      check_val("mid_count", {27'd0, count_o}, 0);
      check_val("mid_tx_data", {24'd0, tx_data_o}, 0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      repeat (12) @(negedge clk);
      check_val("mid_no_done", dones - d0, 0);
      exp_q.push_back(8'h48); exp_q.push_back(8'h69);
      pulse_start();
      wait_done("resend_timeout");
      check_val("resend_count", {27'd0, count_o}, 2);
      check_val("resend_queue", exp_q.size(), 0);
      $display("resend after reset: count=%0d", count_o);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
